// File: rtl/nco_hop_ctrl.sv
// nco_hop_ctrl: frequency-hop scheduler driving NCO phase increment from a programmable hop table.
// Optional FSK frequency modulation output enabled by defining NCO_HOP_FMOD_EN.
module nco_hop_ctrl #(
    parameter int PHASE_W   = 32,
    parameter int DEPTH     = 8,
    parameter int DWELL_W   = 16,
    parameter int PRIME_MAX = 32,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [ADDR_W-1:0]  last_idx,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    input  logic               nco_out_valid,
`ifdef NCO_HOP_FMOD_EN
    input  logic               fsk_i,
    input  logic [PHASE_W-1:0] fmod_dev,
`endif
    output logic [PHASE_W-1:0] nco_phi_inc,
    output logic [PHASE_W-1:0] nco_freq_mod,
    output logic               nco_clken,
    output logic [ADDR_W-1:0]  hop_idx,
    output logic               hop_strobe,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);
    localparam int PW = $clog2(PRIME_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t             state;
    logic [PHASE_W-1:0] inc_tab [DEPTH];
    logic [DWELL_W-1:0] dwell_tab [DEPTH];
    logic [DWELL_W-1:0] dwell_cnt;
    logic [PW-1:0]      prime_cnt;
    logic [ADDR_W-1:0]  next_idx;

    assign next_idx  = (hop_idx == last_idx) ? '0 : hop_idx + 1'b1;
    assign busy      = state != IDLE;
    assign nco_clken = busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            nco_phi_inc <= '0;
            hop_idx     <= '0;
            hop_strobe  <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            dwell_cnt   <= '0;
            prime_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inc_tab[i]   <= '0;
                dwell_tab[i] <= '0;
            end
        end else begin
            hop_strobe <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (start && !stop) begin
                    nco_phi_inc <= inc_tab[0];
                    hop_idx     <= '0;
                    dwell_cnt   <= dwell_tab[0];
                    prime_cnt   <= '0;
                    hop_strobe  <= 1'b1;
                    err_timeout <= 1'b0;
                    state       <= PRIME;
                end
                PRIME: begin
                    prime_cnt <= prime_cnt + 1'b1;
                    if (stop)
                        state <= IDLE;
                    else if (nco_out_valid)
                        state <= RUN;
                    else if (prime_cnt == PW'(PRIME_MAX - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                RUN: begin
                    if (stop)
                        state <= IDLE;
                    else if (dwell_cnt != '0)
                        dwell_cnt <= dwell_cnt - 1'b1;
                    else if (hop_idx != last_idx || loop_en) begin
                        nco_phi_inc <= inc_tab[next_idx];
                        dwell_cnt   <= dwell_tab[next_idx];
                        hop_idx     <= next_idx;
                        hop_strobe  <= 1'b1;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // entries are only sampled on load, so a write here affects the next load of that index
            if (cfg_we) begin
                inc_tab[cfg_addr]   <= cfg_inc;
                dwell_tab[cfg_addr] <= cfg_dwell;
            end
        end
    end

`ifdef NCO_HOP_FMOD_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            nco_freq_mod <= '0;
        else if (nco_clken)
            nco_freq_mod <= fsk_i ? fmod_dev : '0;
    end
`else
    assign nco_freq_mod = '0;
`endif
endmodule
